stream_mux_rr: RTL and testbench

- Parametrised N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshakes.
- Generalises the 2:1 Multiplexer from a combinational 1-bit select to a selectable N:1 data path.
- Two selection modes:
  - fixed (SEL-driven);
  - round-robin (fair among valid inputs).
- Sits between multiple producers and a single consumer; one output register stage.

---
 rtl/mux_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/stream_mux_rr.sv | 109 ++++++++++
 tb/tb_stream_mux_rr.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// ============================================================================
// Module      : mux_pkg
// Description : Shared constants and helpers for the stream multiplexer family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Channel-index width; never narrower than one bit so N=1 still has a port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotate-priority picker; searches PTR+1 .. PTR+N mod N.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = sel_width(N)
) (
    input  logic [N-1:0]    REQ,
    input  logic [SELW-1:0] PTR,
    output logic            GNT_VALID,
    output logic [SELW-1:0] GNT_IDX
);

    // Outer loop is the priority order; inner loop matches the rotated slot to a
    // constant request bit so no variable-index select is needed.
    always_comb begin
        GNT_VALID = 1'b0;
        GNT_IDX   = '0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!GNT_VALID && REQ[i] && (((int'(PTR) + k) % N) == i)) begin
                    GNT_VALID = 1'b1;
                    GNT_IDX   = SELW'(i);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_mux_rr.sv
// ============================================================================
// Module      : stream_mux_rr
// Description : N:1 registered valid/ready stream mux with fixed or round-robin select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_mux_rr
    import mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 8,
    localparam int SELW  = sel_width(N)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N*WIDTH-1:0]   IN_DATA,
    input  logic [N-1:0]         IN_VALID,
    output logic [N-1:0]         IN_READY,
    input  logic [SELW-1:0]      SEL,
    input  logic                 MODE,
    output logic [WIDTH-1:0]     OUT_DATA,
    output logic                 OUT_VALID,
    output logic [SELW-1:0]      OUT_CH,
    input  logic                 OUT_READY
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_ch;
    logic [SELW-1:0]  r_ptr;

    logic             w_load;
    logic             w_rr_valid;
    logic [SELW-1:0]  w_rr_idx;
    logic             w_fix_valid;
    logic [SELW-1:0]  w_fix_idx;
    logic             w_gnt_valid;
    logic [SELW-1:0]  w_gnt_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_gnt_data;

    rr_arbiter #(.N(N)) u_arb (
        .REQ       (IN_VALID),
        .PTR       (r_ptr),
        .GNT_VALID (w_rr_valid),
        .GNT_IDX   (w_rr_idx)
    );

    // A single channel is granted whenever valid, whatever SEL holds.
    generate
        if (N == 1) begin : g_single
            assign w_fix_valid = IN_VALID[0];
            assign w_fix_idx   = '0;
        end else begin : g_multi
            always_comb begin
                w_fix_valid = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (SEL == SELW'(i)) begin
                        w_fix_valid = IN_VALID[i];
                    end
                end
            end
            assign w_fix_idx = SEL;
        end
    endgenerate

    assign w_gnt_valid = (MODE == MODE_FIXED) ? w_fix_valid : w_rr_valid;
    assign w_gnt_idx   = (MODE == MODE_RR)    ? w_rr_idx    : w_fix_idx;
    assign w_load      = !r_out_valid || OUT_READY;
    // Reset wins the edge, so no producer may see a handshake while it is high.
    assign w_xfer      = w_load && w_gnt_valid && !RST;

    always_comb begin
        IN_READY   = '0;
        w_gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt_idx == SELW'(i)) begin
                IN_READY[i] = w_xfer;
                w_gnt_data  = IN_DATA[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= SELW'(N - 1);
        end else if (w_load) begin
            if (w_gnt_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gnt_data;
                r_out_ch    <= w_gnt_idx;
                r_ptr       <= w_gnt_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign OUT_VALID = r_out_valid;
    assign OUT_DATA  = r_out_data;
    assign OUT_CH    = r_out_ch;

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
// ============================================================================
// Module      : tb_stream_mux_rr
// Description : Directed scoreboard bench for stream_mux_rr (N=4 and N=3 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // N=4 instance
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic        mode;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic        out_ready;

    // N=3 instance
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3;
    logic        mode3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic [1:0]  out_ch3;
    logic        out_ready3;

    stream_mux_rr #(.N(4), .WIDTH(8)) dut (
        .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid),
        .IN_READY(in_ready), .SEL(sel), .MODE(mode), .OUT_DATA(out_data),
        .OUT_VALID(out_valid), .OUT_CH(out_ch), .OUT_READY(out_ready)
    );

    stream_mux_rr #(.N(3), .WIDTH(8)) dut3 (
        .CLK(clk), .RST(rst), .IN_DATA(in_data3), .IN_VALID(in_valid3),
        .IN_READY(in_ready3), .SEL(sel3), .MODE(mode3), .OUT_DATA(out_data3),
        .OUT_VALID(out_valid3), .OUT_CH(out_ch3), .OUT_READY(out_ready3)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] ch;
    } item_t;

    item_t      q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    // Reference state of the N=4 output stage
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic [1:0] m_ch    = 2'd0;
    int         m_ptr   = 3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void mgrant(input logic m, input logic [1:0] s, input logic [3:0] v,
                                   input int p, output logic gv, output int gi);
        gv = 1'b0;
        gi = 0;
        if (m == 1'b0) begin
            gv = v[s];
            gi = int'(s);
        end else begin
            for (int k = 1; k <= 4; k++) begin
                if (!gv && v[(p + k) % 4]) begin
                    gv = 1'b1;
                    gi = (p + k) % 4;
                end
            end
        end
    endfunction

    // One clock: check handshake, push expected word, advance, pop and compare.
    task automatic tick();
        logic  ld;
        logic  gv;
        int    gi;
        logic [3:0] er;
        item_t it;
        #1;
        ld = !m_valid || out_ready;
        mgrant(mode, sel, in_valid, m_ptr, gv, gi);
        er = (!rst && ld && gv) ? (4'b0001 << gi) : 4'b0000;
        check("sb_in_ready", {28'd0, in_ready}, {28'd0, er});
        if (!rst && ld && gv) begin
            it.d  = in_data[gi*8 +: 8];
            it.ch = 2'(gi);
            q.push_back(it);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_ch    = 2'd0;
            m_ptr   = 3;
            q.delete();
        end else if (ld) begin
            if (gv) begin
                if (q.size() == 0) begin
                    check("sb_queue_empty", 32'd0, 32'd1);
                end else begin
                    it      = q.pop_front();
                    m_data  = it.d;
                    m_ch    = it.ch;
                    m_valid = 1'b1;
                    m_ptr   = gi;
                end
            end else begin
                m_valid = 1'b0;
            end
        end
        check("sb_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("sb_out_data",  {24'd0, out_data},  {24'd0, m_data});
        check("sb_out_ch",    {30'd0, out_ch},    {30'd0, m_ch});
    endtask

    initial begin
        int seq_all[8];
        int seq_odd[4];
        seq_all = '{0, 1, 2, 3, 0, 1, 2, 3};
        seq_odd = '{1, 3, 1, 3};

        rst        = 1'b1;
        in_data    = {8'h13, 8'h12, 8'h11, 8'h10};
        in_valid   = 4'b1111;
        sel        = 2'd0;
        mode       = 1'b1;
        out_ready  = 1'b1;
        in_data3   = {8'h33, 8'h22, 8'h11};
        in_valid3  = 3'b111;
        sel3       = 2'd3;
        mode3      = 1'b0;
        out_ready3 = 1'b1;

        // Reset for two cycles with every channel valid
        #1;
        check("rst_in_ready", {28'd0, in_ready}, 32'h0);
        tick();
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_ch",    {30'd0, out_ch},    32'd0);

        rst = 1'b0;
        tick();
        check("first_grant_ch", {30'd0, out_ch}, 32'd0);

        // Fixed select
        mode    = 1'b0;
        sel     = 2'd2;
        in_data = {8'h13, 8'hA5, 8'h11, 8'h10};
        #1;
        check("fix_in_ready", {28'd0, in_ready}, 32'b0100);
        tick();
        check("fix_out_data", {24'd0, out_data}, 32'hA5);
        check("fix_out_ch",   {30'd0, out_ch},   32'd2);
        sel      = 2'd3;
        in_valid = 4'b0111;
        #1;
        check("fix_invalid_ready", {28'd0, in_ready}, 32'h0);
        tick();
        check("fix_invalid_drop", {31'd0, out_valid}, 32'd0);

        // Park the pointer on channel 3, then round-robin over all four
        in_valid = 4'b1111;
        in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        tick();
        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr_all_ch", {30'd0, out_ch}, 32'(seq_all[i]));
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_odd_ch", {30'd0, out_ch}, 32'(seq_odd[i]));
        end

        // Backpressure holding 8'h3C
        mode     = 1'b0;
        sel      = 2'd0;
        in_valid = 4'b1111;
        in_data  = {8'h13, 8'h12, 8'h11, 8'h3C};
        tick();
        out_ready = 1'b0;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h77};
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_in_ready", {28'd0, in_ready}, 32'h0);
            tick();
            check("stall_data", {24'd0, out_data}, 32'h3C);
            check("stall_ch",   {30'd0, out_ch},   32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {28'd0, in_ready}, 32'b0001);
        tick();
        check("release_data",  {24'd0, out_data},  32'h77);
        check("release_valid", {31'd0, out_valid}, 32'd1);

        // Reset in the middle of a stall
        mode      = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rst_stall_valid", {31'd0, out_valid}, 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        check("rst_stall_rr_ch", {30'd0, out_ch}, 32'd0);

        // N=3 with an out-of-range select
        for (int i = 0; i < 4; i++) begin
            #1;
            check("oor_in_ready", {29'd0, in_ready3}, 32'h0);
            @(posedge clk);
            #1;
            check("oor_out_valid", {31'd0, out_valid3}, 32'd0);
        end
        sel3 = 2'd1;
        #1;
        check("n3_in_ready", {29'd0, in_ready3}, 32'b010);
        @(posedge clk);
        #1;
        check("n3_out_ch",   {30'd0, out_ch3},   32'd1);
        check("n3_out_data", {24'd0, out_data3}, 32'h22);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
